uart_tx_arbiter: RTL and testbench

Shares the terminal UART's transmit path between two byte producers, the CPU display port and the debug monitor, using round-robin arbitration. It drives the UART's 2-bit register bus as a bus master: it polls the TX status register and issues the TX data write only when the transmitter is idle. After every reset it also issues the one-time dummy TX write that the UART swallows as its init write. It sits between the producers and the UART register port, and never touches the RX registers.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Producer handshakes and UART register-bus signals shared by the TX arbiter.
// The master side is the arbiter; the slave side is the producers plus the UART port.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [1:0] uart_address;
    logic       uart_w_en;
    logic [7:0] uart_din;
    logic       uart_enable;
    logic [7:0] uart_dout;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data, uart_dout,
        output req0_ready, req1_ready, uart_address, uart_w_en, uart_din, uart_enable
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data, uart_dout,
        input  req0_ready, req1_ready, uart_address, uart_w_en, uart_din, uart_enable
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX path between two byte producers;
// polls TX busy before each data write and issues the dummy init write after reset.
module uart_tx_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.master     bus,
    output logic                  busy,
    output logic                  last_grant
);
    localparam int unsigned CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {INIT, SETTLE, IDLE, POLL, CHECK, WRITE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            grant_d;
    logic            winner;
    logic            any_valid;
    logic            unused_bits;

    assign unused_bits = ^{bus.req0_data[7], bus.req1_data[7], bus.uart_dout[6:0]};

    // Tie goes to the producer not served last; otherwise the lone requester wins.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign winner    = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            byte_q     <= '0;
            last_grant <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            last_grant <= grant_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        byte_d           = byte_q;
        grant_d          = last_grant;
        bus.req0_ready   = 1'b0;
        bus.req1_ready   = 1'b0;
        bus.uart_address = 2'b11;
        bus.uart_w_en    = 1'b0;
        bus.uart_din     = '0;
        bus.uart_enable  = 1'b0;

        case (state_q)
            INIT: begin
                bus.uart_address = 2'b10;
                bus.uart_w_en    = 1'b1;
                bus.uart_enable  = 1'b1;
                cnt_d            = CW'(SETTLE_CYCLES - 1);
                state_d          = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                if (any_valid) begin
                    bus.req0_ready = ~winner;
                    bus.req1_ready = winner;
                    byte_d         = {1'b0, winner ? bus.req1_data[6:0] : bus.req0_data[6:0]};
                    grant_d        = winner;
                    state_d        = POLL;
                end
            end
            POLL: begin
                bus.uart_address = 2'b10;
                state_d          = CHECK;
            end
            CHECK: begin
                bus.uart_address = 2'b10;
                if (!bus.uart_dout[7]) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.uart_address = 2'b10;
                bus.uart_w_en    = 1'b1;
                bus.uart_din     = byte_q;
                bus.uart_enable  = 1'b1;
                cnt_d            = CW'(SETTLE_CYCLES - 1);
                state_d          = SETTLE;
            end
            default: state_d = INIT;
        endcase

        // Reset holds state in INIT; keep its write strobe off the bus until release.
        if (rst) begin
            bus.uart_address = 2'b11;
            bus.uart_w_en    = 1'b0;
            bus.uart_din     = '0;
            bus.uart_enable  = 1'b0;
        end
    end

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random producer/UART-busy traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;
    localparam int unsigned S = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic last_grant;
    logic uart_flag = 1'b0;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.SETTLE_CYCLES(S)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    // UART status register model: read data is registered one cycle after the address.
    always @(posedge clk) bus.uart_dout <= {uart_flag, 7'b0};

    bit         v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    bit         rnd_prod = 1'b0, rnd_uart = 1'b0;

    assign bus.req0_valid = v0;
    assign bus.req0_data  = d0;
    assign bus.req1_valid = v1;
    assign bus.req1_data  = d1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Transaction-level model state
    int         m_idle_from, m_write_at, m_accept_at, m_check_from;
    bit         m_pending, m_last;
    logic [7:0] m_byte, m_wbyte;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_addr",  32'(bus.uart_address), 32'h3);
        check_eq("rst_wen",   32'(bus.uart_w_en), 32'h0);
        check_eq("rst_din",   32'(bus.uart_din), 32'h0);
        check_eq("rst_en",    32'(bus.uart_enable), 32'h0);
        check_eq("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'h0);
        check_eq("rst_busy",  32'(busy), 32'h1);
        check_eq("rst_lg",    32'(last_grant), 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        uart_flag = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc          = 0;
        m_pending    = 1'b0;
        m_last       = 1'b1;
        m_write_at   = 0;
        m_wbyte      = 8'h00;
        m_byte       = 8'h00;
        m_accept_at  = -10;
        m_check_from = 0;
        m_idle_from  = 1 + S;
    endtask

    task automatic step();
        bit          idle, exp_w, w, acc0, acc1;
        logic [1:0]  exp_rdy;
        logic [11:0] exp_bus;
        @(negedge clk);
        idle    = !m_pending && (cyc >= m_idle_from);
        exp_w   = (cyc == m_write_at);
        exp_rdy = 2'b00;
        w       = 1'b0;
        if (idle && (v0 || v1)) begin
            w = (v0 && v1) ? !m_last : v1;
            exp_rdy = w ? 2'b10 : 2'b01;
        end
        if (exp_w)                                exp_bus = {2'b10, 1'b1, m_wbyte, 1'b1};
        else if (m_pending && cyc > m_accept_at)  exp_bus = {2'b10, 1'b0, 8'h00, 1'b0};
        else                                      exp_bus = {2'b11, 1'b0, 8'h00, 1'b0};

        check_eq("bus", 32'({bus.uart_address, bus.uart_w_en, bus.uart_din, bus.uart_enable}), 32'(exp_bus));
        check_eq("ready", 32'({bus.req1_ready, bus.req0_ready}), 32'(exp_rdy));
        check_eq("busy", 32'(busy), 32'(!idle));
        check_eq("last_grant", 32'(last_grant), 32'(m_last));
        check_eq("addr_legal", 32'(bus.uart_address[1]), 32'h1);
        check_eq("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'h0);

        if (exp_rdy != 2'b00) begin
            m_pending    = 1'b1;
            m_accept_at  = cyc;
            m_check_from = cyc + 2;
            m_last       = w;
            m_byte       = {1'b0, w ? d1[6:0] : d0[6:0]};
        end else if (m_pending && cyc >= m_check_from && !bus.uart_dout[7]) begin
            m_pending   = 1'b0;
            m_write_at  = cyc + 1;
            m_wbyte     = m_byte;
            m_idle_from = cyc + 2 + S;
        end

        acc0 = bus.req0_ready && v0;
        acc1 = bus.req1_ready && v1;
        @(posedge clk);
        #1;
        cyc++;
        if (acc0) v0 = 1'b0;
        if (acc1) v1 = 1'b0;
        if (rnd_prod) begin
            if (!v0 && $urandom_range(0, 9) < 4) begin v0 = 1'b1; d0 = 8'($urandom); end
            if (!v1 && $urandom_range(0, 9) < 4) begin v1 = 1'b1; d1 = 8'($urandom); end
        end
        if (rnd_uart) uart_flag = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #2;
        do_reset();
        repeat (6) step();

        // Simultaneous pairs: round-robin alternation, then req0 wins the next tie
        v0 = 1'b1; d0 = 8'h31; v1 = 1'b1; d1 = 8'h32;
        repeat (16) step();
        v0 = 1'b1; d0 = 8'h33; v1 = 1'b1; d1 = 8'h34;
        repeat (16) step();

        // Bit 7 of producer data is dropped
        v0 = 1'b1; d0 = 8'hC1;
        repeat (10) step();

        // TX busy held high after the poll
        uart_flag = 1'b1; v1 = 1'b1; d1 = 8'h5A;
        repeat (13) step();
        uart_flag = 1'b0;
        repeat (10) step();

        // Reset while stalled in CHECK with a latched byte
        uart_flag = 1'b1; v0 = 1'b1; d0 = 8'hC5;
        repeat (6) step();
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        do_reset();
        repeat (8) step();

        // Random producers and random TX busy
        rnd_prod = 1'b1;
        rnd_uart = 1'b1;
        repeat (800) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
